// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding, reset PC default,
// NOP word and PC alignment helper.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        WAIT_MEM = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Instruction addresses are word aligned; low bits are dropped on every load.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, load or hold.
// The loaded value is always forced to word alignment.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pcNext,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= align_pc(RESET_PC);
        end else if (load) begin
            pc <= align_pc(pcNext);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC sequencing, redirect handling and imem handshake.
// Optional performance counters are built when INSTRUCTION_FETCH_PERF_EN is defined.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         pcSrc,
    input  logic [31:0]  branchTarget,
    input  logic         jump,
    input  logic [31:0]  jumpTarget,
    output logic         imemReq,
    output logic [31:0]  imemAddr,
    input  logic         imemReady,
    input  logic [31:0]  imemData,
    output logic [31:0]  instruccionOut,
    output logic [31:0]  PC4Out,
    output logic         validOut,
    output logic         flushOut,
`ifdef INSTRUCTION_FETCH_PERF_EN
    output logic [31:0]  fetchCount,
    output logic [31:0]  stallCount,
`endif
    output fetch_state_t fsmState
);

    // Handshake: imemReq/imemAddr name a request; imemReady completes it in the
    // same cycle with imemData valid. Once issued and not ready, the request and
    // address stay stable until imemReady. validOut qualifies instruccionOut/PC4Out
    // for exactly one cycle; there is no backpressure other than stall.

    fetch_state_t state, stateNext;
    logic [31:0]  pc, pcNext, pcPlus4, target, reqAddr, heldData, presentData;
    logic         pcLoad, redirect, present, heldValid, heldSet, heldClr, fetchReq;

    assign redirect = pcSrc | jump;
    assign target   = pcSrc ? branchTarget : jumpTarget;
    assign pcPlus4  = pc + PC_STEP;
    assign fetchReq = !stall && !heldValid;
    assign fsmState = state;

    // In WAIT_MEM/DRAIN the PC may already point at a redirect target.
    assign imemAddr = (state == WAIT_MEM || state == DRAIN) ? reqAddr : pc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (pcLoad),
        .pcNext (pcNext),
        .pc     (pc)
    );

    always_comb begin
        stateNext   = state;
        pcLoad      = 1'b0;
        pcNext      = pcPlus4;
        present     = 1'b0;
        presentData = imemData;
        heldSet     = 1'b0;
        heldClr     = 1'b0;
        imemReq     = 1'b0;
        case (state)
            BOOT: begin
                stateNext = FETCH;
            end
            FETCH: begin
                imemReq = fetchReq;
                if (redirect) begin
                    heldClr = 1'b1;
                    if (fetchReq && !imemReady) begin
                        stateNext = DRAIN;
                    end
                end else if (!stall) begin
                    if (heldValid) begin
                        present     = 1'b1;
                        presentData = heldData;
                        pcLoad      = 1'b1;
                        heldClr     = 1'b1;
                    end else if (imemReady) begin
                        present = 1'b1;
                        pcLoad  = 1'b1;
                    end else begin
                        stateNext = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                imemReq = 1'b1;
                if (redirect) begin
                    stateNext = imemReady ? FETCH : DRAIN;
                end else if (imemReady) begin
                    stateNext = FETCH;
                    if (stall) begin
                        heldSet = 1'b1;
                    end else begin
                        present = 1'b1;
                        pcLoad  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                imemReq = 1'b1;
                if (imemReady) begin
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
        // Redirect outranks stall and any returning word.
        if (redirect) begin
            pcLoad = 1'b1;
            pcNext = target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= BOOT;
            instruccionOut <= NOP;
            PC4Out         <= 32'd0;
            validOut       <= 1'b0;
            flushOut       <= 1'b0;
            heldValid      <= 1'b0;
            heldData       <= NOP;
            reqAddr        <= align_pc(RESET_PC);
        end else begin
            state    <= stateNext;
            validOut <= present;
            flushOut <= redirect;
            if (present) begin
                instruccionOut <= presentData;
                PC4Out         <= pcPlus4;
            end
            if (heldSet) begin
                heldValid <= 1'b1;
                heldData  <= imemData;
            end else if (heldClr) begin
                heldValid <= 1'b0;
            end
            if (state == FETCH) begin
                reqAddr <= pc;
            end
        end
    end

`ifdef INSTRUCTION_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchCount <= 32'd0;
            stallCount <= 32'd0;
        end else begin
            if (present) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (stall || (imemReq && !imemReady)) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: sequential fetch, memory wait,
// redirects over stall, branch/jump priority, drain, held data, wrap and reset.
module tb_instruction_fetch;
    import mips_pkg::*;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         pcSrc;
    logic [31:0]  branchTarget;
    logic         jump;
    logic [31:0]  jumpTarget;
    logic         imemReq;
    logic [31:0]  imemAddr;
    logic         imemReady;
    logic [31:0]  imemData;
    logic [31:0]  instruccionOut;
    logic [31:0]  PC4Out;
    logic         validOut;
    logic         flushOut;
`ifdef INSTRUCTION_FETCH_PERF_EN
    logic [31:0]  fetchCount;
    logic [31:0]  stallCount;
`endif
    fetch_state_t fsmState;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pcSrc          (pcSrc),
        .branchTarget   (branchTarget),
        .jump           (jump),
        .jumpTarget     (jumpTarget),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemData       (imemData),
        .instruccionOut (instruccionOut),
        .PC4Out         (PC4Out),
        .validOut       (validOut),
        .flushOut       (flushOut),
`ifdef INSTRUCTION_FETCH_PERF_EN
        .fetchCount     (fetchCount),
        .stallCount     (stallCount),
`endif
        .fsmState       (fsmState)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic rdy, input logic [31:0] dat);
        stall        = s;
        pcSrc        = br;
        branchTarget = bt;
        jump         = j;
        jumpTarget   = jt;
        imemReady    = rdy;
        imemData     = dat;
        #1;
    endtask

    // One accepted fetch at addr; the word is queued for the scoreboard.
    task automatic fetch_ok(input logic [31:0] addr);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, word_at(addr));
        check("fetch_req", {31'd0, imemReq}, 32'd1);
        check("fetch_addr", imemAddr, addr);
        exp_q.push_back(word_at(addr));
        tick();
    endtask

    task automatic check_valid(input logic [31:0] pc4);
        logic [31:0] w;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("valid", {31'd0, validOut}, 32'd1);
        check("pc4", PC4Out, pc4);
        check("instr", instruccionOut, w);
    endtask

    task automatic check_idle(input string tag, input logic flush);
        check({tag, "_valid"}, {31'd0, validOut}, 32'd0);
        check({tag, "_flush"}, {31'd0, flushOut}, {31'd0, flush});
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        check("rst_req", {31'd0, imemReq}, 32'd0);
        check("rst_instr", instruccionOut, NOP);
        check("rst_pc4", PC4Out, 32'd0);
        check("rst_valid", {31'd0, validOut}, 32'd0);
        check("rst_flush", {31'd0, flushOut}, 32'd0);
        check("rst_state", 32'(fsmState), 32'(BOOT));
        check("rst_addr", imemAddr, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Sequential fetch after reset release, memory always ready
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, word_at(32'd0));
        check("boot_req", {31'd0, imemReq}, 32'd0);
        check("boot_state", 32'(fsmState), 32'(BOOT));
        tick();
        check("c1_valid", {31'd0, validOut}, 32'd0);
        fetch_ok(32'd0);
        check_valid(32'd4);
        fetch_ok(32'd4);
        check_valid(32'd8);

        // Memory not ready for three cycles at PC=8
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            check("wait_req", {31'd0, imemReq}, 32'd1);
            check("wait_addr", imemAddr, 32'd8);
            tick();
            check("wait_valid", {31'd0, validOut}, 32'd0);
        end
        check("wait_state", 32'(fsmState), 32'(WAIT_MEM));
        fetch_ok(32'd8);
        check_valid(32'd12);

        // Branch during stall: flush, outputs held, then fetch at 0x40
        drive(1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1, word_at(32'd12));
        check("stall_req", {31'd0, imemReq}, 32'd0);
        tick();
        check_idle("br_stall", 1'b1);
        check("br_hold_instr", instruccionOut, word_at(32'd8));
        check("br_hold_pc4", PC4Out, 32'd12);
        fetch_ok(32'h40);
        check("br_flush_end", {31'd0, flushOut}, 32'd0);
        check_valid(32'h44);

        // Branch and jump together with memory ready: branch wins, word dropped
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, word_at(32'h44));
        tick();
        check_idle("both", 1'b1);
        check("both_instr", instruccionOut, word_at(32'h40));
        fetch_ok(32'h200);
        check_valid(32'h204);

        // Jump while waiting; late word must be discarded
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 32'd0);
        check("jw_addr", imemAddr, 32'h204);
        tick();
        check_idle("jw", 1'b1);
        check("drain_state", 32'(fsmState), 32'(DRAIN));
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("drain_req", {31'd0, imemReq}, 32'd1);
        check("drain_addr", imemAddr, 32'h204);
        tick();
        check_idle("drain", 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        tick();
        check_idle("drop", 1'b0);
        check("drop_instr", instruccionOut, word_at(32'h200));
        fetch_ok(32'h80);
        check_valid(32'h84);

        // Data returns during stall: held, presented once stall drops
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, word_at(32'h84));
        check("hold_addr", imemAddr, 32'h84);
        exp_q.push_back(word_at(32'h84));
        tick();
        check_idle("held1", 1'b0);
        check("held_instr", instruccionOut, word_at(32'h80));
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("held_req", {31'd0, imemReq}, 32'd0);
        tick();
        check_idle("held2", 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("present_req", {31'd0, imemReq}, 32'd0);
        tick();
        check_valid(32'h88);

        // Unaligned jump target is aligned; fetch at the top wraps to 0
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0);
        tick();
        check_idle("jtop", 1'b1);
        fetch_ok(32'hFFFF_FFFC);
        check_valid(32'd0);
        fetch_ok(32'd0);
        check_valid(32'd4);

        // Asynchronous reset mid-fetch clears outputs without a clock edge
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, validOut}, 32'd0);
        check("arst_instr", instruccionOut, NOP);
        check("arst_pc4", PC4Out, 32'd0);
        check("arst_req", {31'd0, imemReq}, 32'd0);
        check("arst_state", 32'(fsmState), 32'(BOOT));
        check("arst_addr", imemAddr, 32'd0);
        tick();
        reset = 1'b1;

        // A late ready in BOOT is ignored
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("late_valid", {31'd0, validOut}, 32'd0);
        check("late_instr", instruccionOut, NOP);
        fetch_ok(32'd0);
        check_valid(32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 stall  in  1  hazard-unit freeze; 1 holds PC and fetch outputs.
REQ-005 pcSrc  in  1  taken branch; redirect to branchTarget.
REQ-006 branchTarget  in  32  branch destination address.
REQ-007 jump  in  1  jump; redirect to jumpTarget.
REQ-008 jumpTarget  in  32  jump destination address.
REQ-009 imemReq  out  1  instruction-memory request.
REQ-010 imemAddr  out  32  fetch address (current PC).
REQ-011 imemReady  in  1  memory response; imemData valid in the same cycle.
REQ-012 imemData  in  32  fetched instruction word.
REQ-013 instruccionOut  out  32  fetched instruction for the IF/ID register.
REQ-014 PC4Out  out  32  PC+4 of the fetched instruction.
REQ-015 validOut  out  1  instruccionOut/PC4Out hold a new instruction this cycle.
REQ-016 flushOut  out  1  one-cycle pulse; drives IF/ID clear on redirect.

Function
REQ-017 FSM states: BOOT, FETCH, WAIT_MEM, DRAIN.
REQ-018 BOOT: imemReq=0; next cycle goes to FETCH unconditionally.
REQ-019 FETCH, stall=0: imemReq=1, imemAddr=PC.
REQ-020 FETCH, imemReady=1: instruccionOut<=imemData, PC4Out<=PC+4, validOut<=1, PC<=PC+4; stay in FETCH.
REQ-021 FETCH, imemReady=0: go to WAIT_MEM; imemReq and imemAddr stay stable until imemReady.
REQ-022 WAIT_MEM, imemReady=1: capture as REQ-020; return to FETCH.
REQ-023 Any state, stall=1 with no redirect: PC, instruccionOut and PC4Out hold; validOut<=0; from FETCH imemReq=0; in WAIT_MEM/DRAIN the outstanding request completes, and its data is held internally and presented on the first cycle with stall=0.
REQ-024 Redirect (pcSrc or jump) overrides stall: PC<=target, flushOut<=1 for one cycle, validOut<=0.
REQ-025 pcSrc and jump both 1: branchTarget wins (older instruction).
REQ-026 Redirect in WAIT_MEM without imemReady: go to DRAIN; on imemReady, discard imemData and go to FETCH at the new PC.
REQ-027 Redirect in the same cycle as imemReady: the returned word is discarded; no validOut.
REQ-028 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. PC[1:0] is forced to 00 on every load.
REQ-029 Fetch-to-validOut latency is 1 cycle after imemReady.

Reset
REQ-030 While reset=0: PC=RESET_PC, state=BOOT, imemReq=0, instruccionOut=0, PC4Out=0, validOut=0, flushOut=0, held-data buffer empty.
REQ-031 Reset asserted mid-WAIT_MEM abandons the request; the late imemReady is ignored.

Configuration
REQ-032 Macro INSTRUCTION_FETCH_PERF_EN defined: add outputs fetchCount[31:0] (increments per validOut) and stallCount[31:0] (increments per cycle with stall=1 or imemReq=1 and imemReady=0); both reset to 0 and wrap at 2^32.
REQ-033 Macro undefined: these ports and counters are absent; behaviour is otherwise identical.

Structure
REQ-034 Shared package mips_pkg holds the FSM state encoding, the RESET_PC default and the NOP constant 32'h0000_0000.
REQ-035 One sub-module pc_reg holds the PC with load/hold/reset; next-PC selection and the FSM stay in the top module.

Verification
REQ-036 Reset release, imemReady held 1: imemAddr=0,4,8 on consecutive cycles; PC4Out=4,8,12; validOut=1 from cycle 2.
REQ-037 imemReady=0 for 3 cycles at PC=8: imemAddr stays 8 and imemReq=1; validOut=0; then one valid with PC4Out=12.
REQ-038 pcSrc=1 with branchTarget=32'h40 during stall=1: flushOut=1 for one cycle, next imemAddr=32'h40.
REQ-039 jump=1 and pcSrc=1 in the same cycle, with targets 32'h100 and 32'h200: next imemAddr=32'h200.
REQ-040 Redirect to 32'h80 in WAIT_MEM, imemReady 2 cycles later with data 32'hDEADBEEF: that word never appears on instruccionOut, then fetch from 32'h80.
REQ-041 PC=32'hFFFF_FFFC fetch: PC4Out=0, next imemAddr=0; reset=0 mid-fetch clears all outputs asynchronously.
